alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits (legal range 4..64).
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rstN  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  operation request valid.
REQ-005 SHALL provide port in_ready  output  1  block can accept a request.
REQ-006 SHALL provide port a  input  WIDTH  operand A, unsigned.
REQ-007 SHALL provide port b  input  WIDTH  operand B, unsigned.
REQ-008 SHALL provide port opcode  input  2  0=ADD, 1=SUB, 2=MULT, 3=DIV.
REQ-009 SHALL provide port out_valid  output  1  result valid.
REQ-010 SHALL provide port out_ready  input  1  consumer accepts result.
REQ-011 SHALL provide port result  output  2*WIDTH  operation result.
REQ-012 SHALL provide port err  output  1  error flag qualified by out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a request on a clk edge where in_valid&in_ready, capturing a, b, opcode; inputs are ignored at all other times.
REQ-015 ADD: result = zero-extended a+b including carry at bit WIDTH; IDLE->DONE; out_valid on the cycle after accept.
REQ-016 SUB: result low WIDTH bits = a-b modulo 2^WIDTH, bit WIDTH = borrow (a<b), upper bits 0; IDLE->DONE; 1-cycle latency.
REQ-017 MULT: unsigned shift-add, one partial product per cycle over exactly WIDTH cycles in MUL; result = full 2*WIDTH product; out_valid asserted WIDTH+1 cycles after accept.
REQ-018 DIV (b!=0): restoring division, one quotient bit per cycle over exactly WIDTH cycles in DIV; result[WIDTH-1:0]=quotient, result[2*WIDTH-1:WIDTH]=remainder; latency WIDTH+1.
REQ-019 DIV with b==0: IDLE->DONE directly, quotient all ones, remainder = a, err=1; 1-cycle latency.
REQ-020 err SHALL be 0 for every outcome other than REQ-019 and REQ-031.
REQ-021 Iteration counter SHALL be $clog2(WIDTH)+1 bits, cleared on accept, MUL/DIV->DONE when it reaches WIDTH-1 at the end of the final iteration.
REQ-022 DONE: out_valid=1, result and err held stable until out_ready=1; DONE->IDLE on out_valid&out_ready.
REQ-023 No new request accepted in DONE even if out_ready=1 that cycle; next accept earliest the following cycle (max 1 op per 2 cycles).
REQ-024 out_ready while not in DONE SHALL have no effect.
REQ-025 Outputs SHALL be registered; no combinational path from in_* to out_*.

Reset
REQ-026 rstN low SHALL immediately force state IDLE, counter 0, result 0, err 0, out_valid 0, in_ready 1 after release.
REQ-027 Reset asserted mid MUL/DIV or in DONE SHALL abandon the operation with no out_valid pulse; first accept possible on the first clk edge after rstN deasserts.

Configuration
REQ-028 Macro ALU_MC_DIV_EN SHALL control inclusion of the divider datapath and DIV state.
REQ-029 With ALU_MC_DIV_EN defined: DIV behaves per REQ-018/REQ-019.
REQ-030 Without ALU_MC_DIV_EN: no divider logic or DIV state is synthesised.
REQ-031 Without ALU_MC_DIV_EN: opcode DIV goes IDLE->DONE in 1 cycle with result 0 and err=1, regardless of b.

Verification (WIDTH=8 unless stated)
REQ-032 ADD a=8'hFF, b=8'h01 -> out_valid next cycle, result=16'h0100, err=0.
REQ-033 SUB a=8'h03, b=8'h05 -> result=16'h01FE, err=0, 1-cycle latency.
REQ-034 MULT a=8'hFF, b=8'hFF -> out_valid exactly 9 cycles after accept, result=16'hFE01; in_ready=0 throughout.
REQ-035 DIV a=8'd100, b=8'd7 -> 9-cycle latency, result=16'h020E; DIV b=0 a=8'h2A -> result=16'h2AFF, err=1 after 1 cycle; without ALU_MC_DIV_EN any DIV -> result 0, err=1.
REQ-036 MULT accepted, out_ready held 0 for 5 cycles in DONE -> result stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 rstN pulsed low 4 cycles into MULT -> outputs zero immediately, no out_valid; ADD issued after release completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle unsigned ALU (add, sub, shift-add mult, restoring div)
// with a valid/ready request side and a held result until out_ready.
// Ports: clk, rstN (async active-low), in_valid/in_ready, a, b, opcode,
//        out_valid/out_ready, result[2*WIDTH-1:0], err.
// Define ALU_MC_DIV_EN to build the divider; otherwise DIV returns err=1.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [1:0]         opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               err
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef ALU_MC_DIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd3
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // op_q: multiplicand for MUL, divisor for DIV
  logic [WIDTH-1:0]   op_q, op_d;
  // prod_q: {hi, lo}; MUL: {partial, multiplier}, DIV: {rem, dividend/quot}
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               err_q, err_d;

  logic [WIDTH:0]     add_r;
  logic [WIDTH:0]     sub_r;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic               accept;

  assign accept = in_valid && (state_q == S_IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      prod_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unique case (opcode)
            2'd0: state_d = S_DONE;
            2'd1: state_d = S_DONE;
            2'd2: state_d = S_MUL;
            2'd3: begin
`ifdef ALU_MC_DIV_EN
              state_d = (b == '0) ? S_DONE : S_DIV;
`else
              state_d = S_DONE;
`endif
            end
          endcase
        end
      end
      S_MUL: if (cnt_q == LAST) state_d = S_DONE;
`ifdef ALU_MC_DIV_EN
      S_DIV: if (cnt_q == LAST) state_d = S_DONE;
`endif
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = res_q;
    err       = err_q;
  end

  // One shift-add step: add multiplicand into the high half if the
  // current multiplier LSB is set, then shift the whole pair right.
  always_comb begin
    add_r    = {1'b0, a} + {1'b0, b};
    sub_r    = {1'b0, a} - {1'b0, b};
    mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
             + (prod_q[0] ? {1'b0, op_q} : '0);
    mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  // Restoring step: shift next dividend bit into the remainder, keep the
  // subtraction only when it does not go negative.
  always_comb begin
    div_sh  = prod_q[2*WIDTH-1:WIDTH-1];
    div_ge  = (div_sh >= {1'b0, op_q});
    div_rem = div_sh[WIDTH-1:0] - op_q;
    if (div_ge)
      div_next = {div_rem, prod_q[WIDTH-2:0], 1'b1};
    else
      div_next = {prod_q[2*WIDTH-2:0], 1'b0};
  end
`endif

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    prod_d = prod_q;
    res_d  = res_q;
    err_d  = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          err_d = 1'b0;
          unique case (opcode)
            2'd0: begin
              res_d          = '0;
              res_d[WIDTH:0] = add_r;
            end
            2'd1: begin
              res_d          = '0;
              res_d[WIDTH:0] = sub_r;
            end
            2'd2: begin
              op_d   = a;
              prod_d = {{WIDTH{1'b0}}, b};
            end
            2'd3: begin
`ifdef ALU_MC_DIV_EN
              if (b == '0) begin
                res_d = {a, {WIDTH{1'b1}}};
                err_d = 1'b1;
              end else begin
                op_d   = b;
                prod_d = {{WIDTH{1'b0}}, a};
              end
`else
              res_d = '0;
              err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) res_d = mul_next;
      end
`ifdef ALU_MC_DIV_EN
      S_DIV: begin
        prod_d = div_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) res_d = div_next;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=8.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_alu_mc;

  localparam int W = 8;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [1:0]    opcode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [15:0]   result;
  logic          err;

  exp_t q[$];
  exp_t cur;
  bit   seen = 0;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rstN(rstN),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(string nm, logic [1:0] op, logic [7:0] xa,
                       logic [7:0] xb, logic [15:0] er, logic ee, int lat);
    exp_t e;
    int   n = 0;
    a = xa; b = xb; opcode = op; in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      nvec++; nfail++;
      $display("FAIL %s accept timeout", nm);
      in_valid = 1'b0;
      return;
    end
    e.res = er; e.err = ee; e.lat = lat; e.acc = cyc; e.name = nm;
    q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'h5A; b = 8'hA5; opcode = 2'd1;
    if (lat > 1) chk({nm, " busy in_ready"}, 64'(in_ready), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rstN) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        if (q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL unexpected out_valid result %0h", result);
          cur.res = result; cur.err = err; cur.name = "unexp";
        end else begin
          cur = q.pop_front();
          chk({cur.name, " result"}, 64'(result), 64'(cur.res));
          chk({cur.name, " err"}, 64'(err), 64'(cur.err));
          chk({cur.name, " latency"}, 64'(cyc - cur.acc), 64'(cur.lat));
          chk({cur.name, " in_ready"}, 64'(in_ready), 64'd0);
        end
      end else begin
        chk({cur.name, " hold result"}, 64'(result), 64'(cur.res));
        chk({cur.name, " hold err"}, 64'(err), 64'(cur.err));
      end
      if (out_ready) seen = 0;
    end
  end

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (q.size() != 0 || out_valid) begin
      nvec++; nfail++;
      $display("FAIL drain timeout, %0d pending", q.size());
    end
  endtask

  initial begin
    int n;
    #1;
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(posedge clk); #1;

    issue("add ff+01", 2'd0, 8'hFF, 8'h01, 16'h0100, 1'b0, 1);
    issue("add 12+34", 2'd0, 8'h12, 8'h34, 16'h0046, 1'b0, 1);
    issue("sub 03-05", 2'd1, 8'h03, 8'h05, 16'h01FE, 1'b0, 1);
    issue("sub 05-03", 2'd1, 8'h05, 8'h03, 16'h0002, 1'b0, 1);
    issue("sub 00-00", 2'd1, 8'h00, 8'h00, 16'h0000, 1'b0, 1);
    issue("mul ff*ff", 2'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9);
    issue("mul 0d*0b", 2'd2, 8'h0D, 8'h0B, 16'h008F, 1'b0, 9);
    issue("mul 00*55", 2'd2, 8'h00, 8'h55, 16'h0000, 1'b0, 9);
    issue("mul 80*02", 2'd2, 8'h80, 8'h02, 16'h0100, 1'b0, 9);
`ifdef ALU_MC_DIV_EN
    issue("div 100/7", 2'd3, 8'd100, 8'd7, 16'h020E, 1'b0, 9);
    issue("div 2a/0", 2'd3, 8'h2A, 8'h00, 16'h2AFF, 1'b1, 1);
    issue("div ff/1", 2'd3, 8'hFF, 8'h01, 16'h00FF, 1'b0, 9);
    issue("div 5/9", 2'd3, 8'h05, 8'h09, 16'h0500, 1'b0, 9);
`else
    issue("div 100/7", 2'd3, 8'd100, 8'd7, 16'h0000, 1'b1, 1);
    issue("div 2a/0", 2'd3, 8'h2A, 8'h00, 16'h0000, 1'b1, 1);
`endif
    issue("add after div", 2'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1);
    drain();

    // Hold the result in DONE for 5 cycles with out_ready low.
    out_ready = 1'b0;
    issue("mul hold", 2'd2, 8'h03, 8'h05, 16'h000F, 1'b0, 9);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk); #1; n++;
    end
    chk("hold reached done", 64'(out_valid), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("hold out_valid", 64'(out_valid), 64'd1);
      chk("hold in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release out_valid", 64'(out_valid), 64'd0);
    chk("release in_ready", 64'(in_ready), 64'd1);

    // Reset 4 cycles into a multiply: no result may appear.
    issue("mul aborted", 2'd2, 8'hAB, 8'hCD, 16'h88EF, 1'b0, 9);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b0;
    #1;
    chk("abort out_valid", 64'(out_valid), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort err", 64'(err), 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    issue("add post-rst", 2'd0, 8'h01, 8'h02, 16'h0003, 1'b0, 1);
    issue("sub post-rst", 2'd1, 8'h10, 8'h01, 16'h000F, 1'b0, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
